// File: rtl/multi_port_ram.sv
// multi_port_ram: N-port word-addressed RAM sharing one single-ported storage array.
// A combinational arbiter (fixed priority or round-robin) grants at most one port per cycle;
// the granted port gets a registered response (rvalid/rdata/err) exactly one cycle later.
// Accesses beyond DEPTH words return an error response and never touch the array.

module multi_port_ram #(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ARB_MODE   = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_PORTS-1:0]              req_i,
    input  logic [NUM_PORTS-1:0]              we_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]              gnt_o,
    output logic [NUM_PORTS-1:0]              rvalid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata_o,
    output logic [NUM_PORTS-1:0]              err_o
);

    localparam int unsigned BeWidth = DATA_WIDTH / 8;
    localparam int unsigned OffBits = (BeWidth > 1) ? $clog2(BeWidth) : 0;
    localparam int unsigned PtrW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned MemAw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Arbitration
    logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  gnt_valid;
    logic [PtrW-1:0]       gnt_idx;
    int unsigned           arb_base;
    int unsigned           arb_cand;

    // Granted request, muxed from the winning port
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [BeWidth-1:0]    sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [31:0]           sel_word;
    logic                  sel_inrange;
    logic                  mem_en;
    logic [MemAw-1:0]      mem_idx;

    // Response tracking
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_we_q, rsp_we_d;
    logic [PtrW-1:0]       rsp_idx_q, rsp_idx_d;

    // Storage (not reset)
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] mem_rdata_q;

    // Pick the first requesting port, searching upward from the base (0 or rr pointer)
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt_o     = '0;
        arb_cand  = 0;
        arb_base  = (ARB_MODE == 1) ? 32'(rr_ptr_q) : 32'd0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            arb_cand = (arb_base + k) % NUM_PORTS;
            if (!gnt_valid && req_i[arb_cand]) begin
                gnt_valid       = 1'b1;
                gnt_idx         = PtrW'(arb_cand);
                gnt_o[arb_cand] = 1'b1;
            end
        end
        // No grants while reset is held, so nothing is launched into the array
        if (!rst_ni) begin
            gnt_valid = 1'b0;
            gnt_o     = '0;
        end
    end

    // Route the granted port's request to the array and classify its address
    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_wdata = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (gnt_o[p]) begin
                sel_addr  = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_we    = we_i[p];
                sel_be    = be_i[p*BeWidth +: BeWidth];
                sel_wdata = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        // Byte-offset bits are simply shifted away; no misalignment handling
        sel_word    = 32'(sel_addr >> OffBits);
        sel_inrange = (sel_word < DEPTH);
        mem_en      = gnt_valid && sel_inrange;
        mem_idx     = MemAw'(sel_word);
    end

    // Next-state for the response tracker and round-robin pointer
    always_comb begin
        rsp_valid_d = gnt_valid;
        rsp_idx_d   = gnt_idx;
        rsp_err_d   = gnt_valid && !sel_inrange;
        rsp_we_d    = sel_we;
        rr_ptr_d    = rr_ptr_q;
        if (gnt_valid) begin
            rr_ptr_d = (32'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + PtrW'(1);
        end
    end

    // Control state with asynchronous reset; a pending response is dropped on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_idx_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_we_q    <= rsp_we_d;
            rsp_idx_q   <= rsp_idx_d;
        end
    end

    // Single-port array: byte-masked write or registered read, one access per cycle
    always_ff @(posedge clk_i) begin
        if (mem_en) begin
            if (sel_we) begin
                for (int unsigned b = 0; b < BeWidth; b++) begin
                    if (sel_be[b]) begin
                        mem[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                    end
                end
            end else begin
                mem_rdata_q <= mem[mem_idx];
            end
        end
    end

    // Steer the response to the port that was granted; all other slices stay zero
    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (rsp_valid_q && (32'(rsp_idx_q) == p)) begin
                rvalid_o[p] = 1'b1;
                err_o[p]    = rsp_err_q;
                if (!rsp_err_q && !rsp_we_q) begin
                    rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = mem_rdata_q;
                end
            end
        end
    end

endmodule

// File: doc/multi_port_ram.md
# multi_port_ram

Parametrised N-port word-addressed RAM with built-in arbitration, replacing the fixed three-port (instruction / core data / UART loader) RAM in the SoC top level. Each port speaks the core's req/gnt/rvalid memory protocol. A single-ported storage array is shared by all requestors through a fixed-priority or round-robin arbiter. Out-of-range accesses report an error response instead of aliasing.

## Interface
- NUM_PORTS, 3, number of requestor ports (1..8); port 0 is highest priority in fixed mode
- ADDR_WIDTH, 12, byte-address width per port
- DATA_WIDTH, 32, word width; must be a multiple of 8
- DEPTH, 1024, number of words implemented
- ARB_MODE, 0, 0 = fixed priority, 1 = round-robin
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NUM_PORTS  per-port request
- we_i  in  NUM_PORTS  per-port write enable (1 = write)
- be_i  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables, port p at slice p
- addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port byte address
- wdata_i  in  NUM_PORTS*DATA_WIDTH  per-port write data
- gnt_o  out  NUM_PORTS  grant, one-hot or zero
- rvalid_o  out  NUM_PORTS  response valid, one cycle after grant
- rdata_o  out  NUM_PORTS*DATA_WIDTH  read data, valid with rvalid_o
- err_o  out  NUM_PORTS  error flag, valid with rvalid_o

## Operation
- Word index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]. Low byte-offset bits are ignored; no misalignment handling.
- Arbiter is combinational over req_i. At most one gnt_o bit is set per cycle, and only when its req_i is set.
- Fixed mode: the lowest-index requesting port wins.
- Round-robin mode: search starts at pointer rr_ptr and wraps. On any grant, rr_ptr <= granted index + 1, wrapping at NUM_PORTS. No grant leaves rr_ptr unchanged.
- Granted write, in range: each byte lane with be=1 is written at the clock edge. be all zero writes nothing but still responds.
- Granted read, in range: the word is latched and returned next cycle.
- Response: in the cycle after the grant, rvalid_o[p]=1 for the granted port only. rdata_o slice p carries read data, or 0 for writes. err_o[p]=0.
- Out of range (word index >= DEPTH): no array access, rvalid_o[p]=1, err_o[p]=1, rdata_o slice = 0.
- Ungranted ports hold req/addr/we/be/wdata stable until granted. The block tolerates changes on those signals but gives no response to a dropped request.
- Response for port p is tracked by a registered port index plus valid. Non-responding port rdata slices are 0.
- Storage is an inferred single-port array; contents are not reset.

## Timing
- Reset asserted (async): rvalid_o=0, err_o=0, rdata_o=0, rr_ptr=0, gnt_o=0 (gated combinationally while rst_ni=0).
- Reset mid-transaction: a pending response is discarded (rvalid_o stays 0). A write granted in the cycle reset asserts is not guaranteed.
- Grant latency: 0 cycles (gnt_o in the same cycle as req_i when that port wins).
- Response latency: exactly 1 cycle after the gnt cycle.
- Throughput: one access per cycle across all ports; back-to-back grants to the same port are allowed.
- Read-after-write to the same word in consecutive cycles returns the newly written data.
- A port receiving a new grant in cycle t+1 while its response from cycle t is in flight sees rvalid in t+1 and t+2. Responses stay in order.

## Test plan
- Single port, NUM_PORTS=3, ARB_MODE=0: port 1 writes 0xDEADBEEF at addr 0x010, be=4'hF, then reads 0x010 -> gnt same cycle each; read rvalid next cycle with rdata=0xDEADBEEF, err=0.
- Byte enables: write 0x11223344 to 0x020, then 0xAABBCCDD with be=4'b0101, then read -> rdata=0x11BB33DD; write with be=0 then read -> unchanged.
- Fixed priority: ports 0, 1, 2 all request reads continuously -> port 0 granted every cycle, ports 1 and 2 never. Drop port 0 -> port 1 granted next cycle.
- Round-robin (ARB_MODE=1): all three ports request continuously for 6 cycles -> grant sequence 0,1,2,0,1,2. Each rvalid lags its gnt by 1 cycle.
- Out of range, DEPTH=1024: read at 0x1000 with ADDR_WIDTH=13 -> rvalid=1, err=1, rdata=0. A write there leaves word 0 unchanged.
- Reset: pulse rst_ni low asynchronously mid-clock between a read grant and its response -> rvalid_o, err_o and rdata_o drop to 0 immediately and no response follows. After release, rr_ptr restarts at port 0.
